// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU/SRAM/OAM fabric and the sprite DMA sequencer.
// The fabric side (master) supplies the CPU write strobe and SRAM read data;
// the sequencer side (slave) owns the DMA flag, shared address, OAM data and strobe.
interface oam_dma_if;
   logic        ce;     // one clk pulse per CPU cycle
   logic [15:0] ea;     // CPU effective (write) address
   logic [7:0]  dout;   // CPU write data
   logic        wreq;   // CPU write request
   logic [7:0]  din;    // registered SRAM read data
   logic        dma;    // transfer owns the bus
   logic [15:0] waddr;  // shared SRAM/OAM address
   logic [7:0]  wdata;  // byte written to OAM
   logic        oamw;   // OAM write strobe

   modport master (
      output ce, ea, dout, wreq, din,
      input  dma, waddr, wdata, oamw
   );

   modport slave (
      input  ce, ea, dout, wreq, din,
      output dma, waddr, wdata, oamw
   );
endinterface : oam_dma_if

// File: rtl/oam_dma.sv
// Sprite DMA sequencer: a CPU write to $4014 latches a source page and copies
// 256 bytes from {page, idx} into OAM, one read CPU cycle and one write CPU
// cycle per byte, after a halt cycle and an optional parity-alignment cycle.
module oam_dma (
   input  logic      clk,
   input  logic      reset,
   oam_dma_if.slave  bus
);

   localparam logic [15:0] DMA_REG = 16'h4014;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_ALIGN,
      ST_RD,
      ST_WR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  page_q,  page_d;
   logic [7:0]  idx_q,   idx_d;
   logic [7:0]  rbuf_q,  rbuf_d;
   logic        odd_q,   odd_d;

   // State register: every flop advances from its _d value; reset wins over ce.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         rbuf_q  <= 8'h00;
         odd_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         rbuf_q  <= rbuf_d;
         odd_q   <= odd_d;
      end
   end

   // Next-state logic: everything moves only on a CPU-cycle strobe.
   always_comb begin
      // NOTE: hold values are assigned up front so no path leaves a variable unassigned (no latch).
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      rbuf_d  = rbuf_q;
      odd_d   = odd_q;

      if (bus.ce) begin
         odd_d = ~odd_q;
         case (state_q)
            ST_IDLE: begin
               // $4014 writes outside IDLE never reach this branch, so they are ignored.
               if (bus.wreq && (bus.ea == DMA_REG)) begin
                  page_d  = bus.dout;
                  idx_d   = 8'h00;
                  state_d = ST_HALT;
               end
            end
            ST_HALT: begin
               // An odd halt cycle needs one dummy cycle so reads land on even cycles.
               state_d = odd_q ? ST_ALIGN : ST_RD;
            end
            ST_ALIGN: begin
               state_d = ST_RD;
            end
            ST_RD: begin
               // din has had at least 3 clk to settle since waddr became stable.
               rbuf_d  = bus.din;
               state_d = ST_WR;
            end
            ST_WR: begin
               // idx wraps FF->00 on the last byte, leaving it ready for the next transfer.
               idx_d   = idx_q + 8'd1;
               state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_RD;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode: bus ownership, shared address, OAM data and write strobe.
   always_comb begin
      bus.dma   = (state_q != ST_IDLE);
      bus.waddr = 16'h0000;
      bus.wdata = rbuf_q;
      bus.oamw  = 1'b0;
      case (state_q)
         ST_RD: begin
            // The page never absorbs a carry from idx: page FF reads FF00-FFFF only.
            bus.waddr = {page_q, idx_q};
         end
         ST_WR: begin
            bus.waddr = {8'h00, idx_q};
            // Strobe only on the clk that ends the write cycle; a reset cycle writes nothing.
            bus.oamw  = bus.ce && !reset;
         end
         default: begin
            bus.waddr = 16'h0000;
         end
      endcase
   end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: SRAM and OAM behaviour models, a transfer-level
// reference model compared against the DUT every clk, plus literal expectations.
module tb_oam_dma;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   oam_dma_if bus ();

   oam_dma dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem [0:65535];
   logic [7:0] oam [0:255];

   // Registered SRAM: data valid one clk after the address.
   always @(posedge clk) bus.din <= mem[bus.waddr];

   // OAM write port.
   always @(posedge clk) if (bus.oamw) oam[bus.waddr[7:0]] <= bus.wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Source data pattern per page; unused pages hold CC so a wrong page is visible.
   function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] i);
      case (pg)
         8'h02:   return i ^ 8'hA5;
         8'h03:   return ~i;
         8'h04:   return 8'(i * 3 + 1);
         8'h07:   return 8'h77;
         8'hFF:   return 8'(i + 8'h30);
         default: return 8'hCC;
      endcase
   endfunction

   // ---------------- transfer-level reference model ----------------
   // A transfer is counted in CPU cycles k from the halt cycle: k=0 halt,
   // k=1 align (only if the halt cycle was odd), then 512 cycles alternating
   // read / write of byte j/2.
   bit         m_active;
   int         m_k;
   bit         m_align;
   bit         m_par;
   logic [7:0] m_page;
   logic [7:0] m_rbuf;

   function automatic int phase_of(input int k, input bit al);
      int j;
      if (k == 0) return 0;
      if (al && k == 1) return 1;
      j = k - 1 - int'(al);
      return ((j % 2) == 0) ? 2 : 3;
   endfunction

   function automatic logic [7:0] byte_of(input int k, input bit al);
      int j;
      j = k - 1 - int'(al);
      return 8'(j / 2);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_align  <= 1'b0;
         m_par    <= 1'b0;
         m_page   <= 8'h00;
         m_rbuf   <= 8'h00;
      end else if (bus.ce) begin
         m_par <= ~m_par;
         if (!m_active) begin
            if (bus.wreq && bus.ea == 16'h4014) begin
               m_active <= 1'b1;
               m_k      <= 0;
               m_page   <= bus.dout;
            end
         end else begin
            if (m_k == 0) m_align <= m_par;
            if (m_k > 0 && phase_of(m_k, m_align) == 2)
               m_rbuf <= mem[{m_page, byte_of(m_k, m_align)}];
            if (m_k > 0 && phase_of(m_k, m_align) == 3 && byte_of(m_k, m_align) == 8'hFF)
               m_active <= 1'b0;
            m_k <= m_k + 1;
         end
      end
   end

   // ---------------- per-clk comparison against the model ----------------
   bit          cmp_en = 1'b0;
   int          e_ph;
   logic [15:0] e_waddr;
   logic        e_oamw;
   int          dma_ce_cnt;
   int          oamw_cnt;
   logic [15:0] addr_q [$];

   always @(negedge clk) begin
      if (cmp_en) begin
         e_ph = m_active ? phase_of(m_k, m_align) : 0;
         if (m_active && e_ph == 2)      e_waddr = {m_page, byte_of(m_k, m_align)};
         else if (m_active && e_ph == 3) e_waddr = {8'h00, byte_of(m_k, m_align)};
         else                            e_waddr = 16'h0000;
         e_oamw = m_active && (e_ph == 3) && bus.ce && !reset;
         check("dma",   32'(bus.dma),   32'(m_active));
         check("waddr", 32'(bus.waddr), 32'(e_waddr));
         check("wdata", 32'(bus.wdata), 32'(m_rbuf));
         check("oamw",  32'(bus.oamw),  32'(e_oamw));
         if (bus.ce && bus.dma) begin
            dma_ce_cnt++;
            addr_q.push_back(bus.waddr);
         end
         if (bus.oamw) oamw_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   // One CPU cycle: ce high for one clk, then three quiet clks.
   task automatic cpu_cycle(input logic w, input logic [15:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.ce   = 1'b1;
      bus.wreq = w;
      bus.ea   = a;
      bus.dout = d;
      @(posedge clk);
      #1;
      bus.ce   = 1'b0;
      bus.wreq = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic idle_cycle();
      cpu_cycle(1'b0, 16'h0000, 8'h00);
   endtask

   // Trigger with a chosen halt-cycle parity (align=1 means odd halt cycle).
   task automatic trigger_dma(input logic [7:0] pg, input bit want_align);
      if (m_par != (want_align ? 1'b0 : 1'b1)) idle_cycle();
      dma_ce_cnt = 0;
      oamw_cnt   = 0;
      addr_q.delete();
      cpu_cycle(1'b1, 16'h4014, pg);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 700; n++) begin
         idle_cycle();
         if (!bus.dma) break;
      end
      check("dma_done", 32'(bus.dma), 32'd0);
   endtask

   task automatic wait_addr(input string name, input logic [15:0] a);
      for (int n = 0; n < 700; n++) begin
         idle_cycle();
         if (bus.waddr == a) break;
      end
      check(name, 32'(bus.waddr), 32'(a));
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
   endtask

   task automatic check_oam(input logic [7:0] pg, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         check($sformatf("oam[%02h]", i), 32'(oam[i]), 32'(pat(pg, 8'(i))));
   endtask

   task automatic check_oam_untouched(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         check($sformatf("oam_keep[%02h]", i), 32'(oam[i]), 32'h000000EE);
   endtask

   // Watchdog: the run is a few tens of thousands of clks.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int ff_reads;
      reset    = 1'b1;
      bus.ce   = 1'b0;
      bus.wreq = 1'b0;
      bus.ea   = 16'h0000;
      bus.dout = 8'h00;
      for (int a = 0; a < 65536; a++) mem[a] = pat(8'(a >> 8), 8'(a));
      clear_oam();
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset values.
      @(negedge clk);
      check("rst_dma",   32'(bus.dma),   32'd0);
      check("rst_waddr", 32'(bus.waddr), 32'd0);
      check("rst_wdata", 32'(bus.wdata), 32'd0);
      check("rst_oamw",  32'(bus.oamw),  32'd0);

      // A trigger coinciding with reset must not start a transfer.
      @(posedge clk);
      #1;
      reset    = 1'b1;
      bus.ce   = 1'b1;
      bus.wreq = 1'b1;
      bus.ea   = 16'h4014;
      bus.dout = 8'h02;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      bus.ce   = 1'b0;
      bus.wreq = 1'b0;
      idle_cycle();
      idle_cycle();
      check("rst_trig_dma", 32'(bus.dma), 32'd0);

      // Writes to other addresses have no effect.
      oamw_cnt = 0;
      cpu_cycle(1'b1, 16'h4015, 8'h02);
      cpu_cycle(1'b1, 16'h2014, 8'h5A);
      cpu_cycle(1'b1, 16'hC014, 8'hFF);
      idle_cycle();
      check("nontrig_dma",  32'(bus.dma), 32'd0);
      check("nontrig_oamw", 32'(oamw_cnt), 32'd0);

      // Even-parity halt cycle: 513 DMA CPU cycles.
      clear_oam();
      trigger_dma(8'h02, 1'b0);
      wait_idle();
      check("even_cycles", 32'(dma_ce_cnt), 32'd513);
      check("even_oamw",   32'(oamw_cnt),   32'd256);
      check("even_a0", 32'(addr_q[0]), 32'h0000);
      check("even_a1", 32'(addr_q[1]), 32'h0200);
      check("even_a2", 32'(addr_q[2]), 32'h0000);
      check("even_a3", 32'(addr_q[3]), 32'h0201);
      check("even_a4", 32'(addr_q[4]), 32'h0001);
      check_oam(8'h02, 0, 255);

      // Odd-parity halt cycle: extra align cycle, 514 DMA CPU cycles.
      clear_oam();
      trigger_dma(8'h02, 1'b1);
      wait_idle();
      check("odd_cycles", 32'(dma_ce_cnt), 32'd514);
      check("odd_oamw",   32'(oamw_cnt),   32'd256);
      check("odd_a1", 32'(addr_q[1]), 32'h0000);
      check("odd_a2", 32'(addr_q[2]), 32'h0200);
      check("odd_a3", 32'(addr_q[3]), 32'h0000);
      check("odd_a4", 32'(addr_q[4]), 32'h0201);
      check_oam(8'h02, 0, 255);

      // Page FF: reads stay inside FF00-FFFF.
      clear_oam();
      trigger_dma(8'hFF, 1'b0);
      wait_idle();
      ff_reads = 0;
      foreach (addr_q[i]) if (addr_q[i][15:8] == 8'hFF) ff_reads++;
      check("ff_reads",   32'(ff_reads), 32'd256);
      check("ff_last_rd", 32'(addr_q[addr_q.size() - 2]), 32'h0000FFFF);
      check("ff_last_wr", 32'(addr_q[addr_q.size() - 1]), 32'h000000FF);
      check("ff_oamw",    32'(oamw_cnt), 32'd256);
      check_oam(8'hFF, 0, 255);

      // Re-trigger during a transfer is ignored.
      clear_oam();
      trigger_dma(8'h02, 1'b0);
      wait_addr("retrig_reach", 16'h0240);
      cpu_cycle(1'b1, 16'h4014, 8'h07);
      wait_idle();
      check("retrig_cycles", 32'(dma_ce_cnt), 32'd513);
      check("retrig_oamw",   32'(oamw_cnt),   32'd256);
      check_oam(8'h02, 0, 255);

      // Reset in the middle of a transfer, then a fresh transfer from idx 0.
      clear_oam();
      trigger_dma(8'h04, 1'b0);
      wait_addr("midrst_reach", 16'h0480);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_dma",   32'(bus.dma),   32'd0);
      check("midrst_oamw",  32'(bus.oamw),  32'd0);
      check("midrst_waddr", 32'(bus.waddr), 32'd0);
      check("midrst_wdata", 32'(bus.wdata), 32'd0);
      check("midrst_count", 32'(oamw_cnt),  32'd128);
      check_oam(8'h04, 0, 127);
      check_oam_untouched(128, 255);
      trigger_dma(8'h03, 1'b0);
      wait_idle();
      check("p3_a1",     32'(addr_q[1]),  32'h0300);
      check("p3_cycles", 32'(dma_ce_cnt), 32'd513);
      check("p3_oamw",   32'(oamw_cnt),   32'd256);
      check_oam(8'h03, 0, 255);

      @(posedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_oam_dma

// File: doc/oam_dma.md
# oam_dma

Sprite DMA sequencer between the CPU, the shared SRAM port and sprite OAM. A CPU write to $4014 latches a source page and starts a 256-byte copy from CPU address space to OAM. The copy halts the CPU, drives the shared memory address `curaddr` through `waddr`, and issues one OAM write per byte. The block owns the `dma`, `waddr` (during DMA), `wdata` and `oamw` nets that feed the SRAM address mux and the OAM write port.

## Interface
- `DMA_REG`, 16'h4014, CPU address that triggers a transfer
- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  synchronous, active-high
- `ce`  in  1  CPU-cycle strobe: one `clk` pulse per CPU cycle; successive pulses are ≥3 `clk` apart
- `ea`  in  16  CPU effective (write) address
- `dout`  in  8  CPU write data
- `wreq`  in  1  CPU write request
- `din`  in  8  memory read data; registered SRAM, valid 1 `clk` after `waddr` is stable
- `dma`  out  1  high while a transfer owns the bus; gates CPU clock-enable and selects `waddr` into SRAM
- `waddr`  out  16  {page, idx} in the read phase; {8'h00, idx} in the write phase; 0 when idle
- `wdata`  out  8  byte being written to OAM
- `oamw`  out  1  OAM write strobe, one `clk` wide

## Operation
- Registers:
  - `page[7:0]`
  - `idx[7:0]`
  - `rbuf[7:0]`
  - `odd`: CPU-cycle parity, toggles on every `ce`, reset 0
  - `state`
- Trigger: at `ce` with `wreq=1` and `ea==DMA_REG` while in IDLE:
  - `page <= dout`, `idx <= 0`, go to HALT.
- States:
  - IDLE: `dma=0`.
  - HALT: 1 CPU cycle. On the next `ce`, go to ALIGN if `odd==1`, else go to RD.
  - ALIGN: 1 dummy CPU cycle. On the next `ce`, go to RD.
  - RD: `waddr={page,idx}`. On `ce`, `rbuf<=din` and go to WR.
  - WR: `waddr={8'h00,idx}` and `wdata=rbuf`. `oamw=1` on the `ce` clk only.
    - On `ce` with `idx==8'hFF`, go to IDLE.
    - Otherwise `idx<=idx+1` and go to RD.
- `idx` is 8-bit and wraps FF→00 at completion. The read address never carries into `page`; page FF reads FF00–FFFF only.
- `$4014` writes while `state≠IDLE` are ignored.
- Writes to any other address have no effect.
- `wdata` holds `rbuf` in all states. `oamw` is asserted only in WR.

## Timing
- Reset values: `dma=0`, `waddr=0`, `wdata=0`, `oamw=0`, `state=IDLE`, `idx=0`, `page=0`, `odd=0`.
- `dma` rises on the `clk` after the trigger `ce`. It falls on the `clk` after the final WR `ce`.
- CPU cycles with `dma=1`:
  - 1 (HALT) + 512 (RD/WR) = 513 when `odd=0` at the HALT `ce`.
  - 514 when `odd=1` (adds ALIGN).
- Read latency: address is stable from the `clk` after entering RD. `din` is sampled at the ending `ce`, ≥3 `clk` later.
- OAM write: `oamw` is high for exactly the `clk` where `ce=1` in WR. `waddr[7:0]=idx` and `wdata` are stable across it.
- A trigger `ce` coinciding with `reset`: reset wins and no transfer starts.
- `reset` mid-transfer: outputs return to reset values on the next `clk`. OAM keeps the bytes already written. The next `$4014` write starts again at `idx=0`.
- `ce` is ignored while `reset=1`. `odd` restarts at 0.

## Test plan
- Even-parity trigger: fill SRAM 0x0200+i with i^8'hA5, write `$4014=8'h02` → `dma` high for exactly 513 `ce`s, 256 `oamw` pulses, OAM[i]==i^8'hA5, `waddr` sequence 0x0200,0x0000,0x0201,0x0001…
- Odd-parity trigger: same transfer, trigger issued one CPU cycle later → `dma` high for 514 `ce`s, first RD address 0x0200 appears after the ALIGN cycle, OAM contents identical.
- Page wrap: write `$4014=8'hFF` → reads FF00–FFFF, last RD `waddr`=0xFFFF, no access to 0x0000–0x00FF in the read phase, `dma` falls after `idx`=FF.
- Re-trigger during DMA: bench forces `wreq` with `ea=16'h4014`, `dout=8'h07` at `idx`=0x40 → `page` stays 0x02, transfer completes normally with 256 writes.
- Reset mid-transfer: assert `reset` one `clk` at `idx`=0x80 → next `clk` `dma=0`, `oamw=0`, `waddr=0`. OAM[0..7F] already hold the new data. A new `$4014=8'h03` copies 0x0300–0x03FF starting from `idx` 0.
- Non-trigger writes: writes to 16'h4015, 16'h2014, 16'hC014 with any data → `dma`, `oamw` stay 0.
